pdm_fade_ctrl: RTL
==================

PDM_FADE_CTRL -- requirements
Module: pdm_fade_ctrl

Interface
REQ-001 Parameter MOD_WIDTH, 8, width of the modulation setpoint and target, in bits.
REQ-002 Parameter STEP_WIDTH, 16, width of the step_period prescaler, in bits.
REQ-003 Parameter RESET_SETPOINT, 0, value of mod_setpoint after reset.
REQ-004 The port list SHALL be exactly: clk (in, 1, system clock, single clock domain); rst (in, 1, reset, synchronous, active-high).
REQ-005 Ports continued: target (in, MOD_WIDTH, requested final setpoint); target_valid (in, 1, target request strobe).
REQ-006 Ports continued: ready (out, 1, request accepted this cycle when target_valid is also 1); step_period (in, STEP_WIDTH, clk cycles between steps, sampled on each reload).
REQ-007 Ports continued: abort (in, 1, stop the ramp and hold the current setpoint); pdm_start_strobe (in, 1, modulator period-start strobe).
REQ-008 Ports continued: mod_setpoint (out, MOD_WIDTH, drives the modulator setpoint); busy (out, 1, ramp in progress); done (out, 1, one-cycle pulse on ramp completion).

Function
REQ-009 The FSM SHALL have states IDLE, COUNT, APPLY; busy SHALL be 1 exactly in COUNT and APPLY.
REQ-010 IDLE, target_valid=1: latch target. If target==mod_setpoint, pulse done next cycle and stay in IDLE; else load prescaler and enter COUNT.
REQ-011 Prescaler load value SHALL be max(step_period,1)-1; step_period=0 SHALL behave as 1.
REQ-012 COUNT: decrement prescaler by 1 per clk; at 0 enter APPLY next cycle.
REQ-013 APPLY: wait for pdm_start_strobe=1. In that cycle mod_setpoint SHALL move one LSB toward the latched target, registered, visible next cycle.
REQ-014 mod_setpoint SHALL change only in APPLY on a strobe cycle, never by more than 1 LSB, and never wrap below 0 or above 2**MOD_WIDTH-1.
REQ-015 After a step, if the new value equals the target: pulse done and return to IDLE. Otherwise reload the prescaler from the current step_period and enter COUNT.
REQ-016 abort=1 in any state SHALL return the FSM to IDLE next cycle, hold mod_setpoint, and suppress done.
REQ-017 abort SHALL take priority over target_valid and over a step in the same cycle.
REQ-018 A pdm_start_strobe outside APPLY SHALL be ignored and not remembered.
REQ-019 ready SHALL equal (state==IDLE) and not abort, except as modified in REQ-024.
REQ-020 Ramp time for distance N SHALL be at least N*max(step_period,1) cycles; each step adds the wait for the next strobe.

Reset
REQ-021 While rst=1 at a clk edge: state=IDLE, mod_setpoint=RESET_SETPOINT, latched target=RESET_SETPOINT, prescaler=0, busy=0, done=0, ready=0.
REQ-022 rst mid-ramp SHALL discard the ramp with no done pulse; ready=1 the first cycle after rst deasserts.

Configuration
REQ-023 Macro PDM_FADE_CTRL_RETARGET_EN SHALL select retarget-while-busy behaviour.
REQ-024 Defined: ready = not abort in all states. target_valid in COUNT/APPLY replaces the latched target without resetting the prescaler or changing state; the step direction is re-evaluated at the next step. If the new target equals mod_setpoint, go to IDLE next cycle with a done pulse.
REQ-025 Undefined: ready=0 while busy, and target_valid in COUNT/APPLY SHALL be ignored with no state effect.

Verification
REQ-026 Reset, then target=10, step_period=4, strobe every 8 cycles: mod_setpoint goes 0->10 in 10 single-LSB steps, each aligned to a strobe; one done pulse; busy falls with done.
REQ-027 Setpoint at 200, target=195, step_period=0, strobe every cycle: decrements every 2 cycles to 195; no underflow; done pulses once.
REQ-028 target equal to mod_setpoint (=37) in IDLE: no setpoint change, done pulses next cycle, busy stays 0.
REQ-029 Ramp 0->255, abort asserted on the same cycle as a step strobe at value 100: setpoint holds 100, no done pulse, IDLE next cycle. Ramping to 255 and to 0 never wraps.
REQ-030 rst at setpoint 50 mid-ramp: mod_setpoint=RESET_SETPOINT, busy=0, no done pulse.
REQ-031 With the macro defined, retarget 10->5 at setpoint 7: ramp reverses and ends at 5. Without the macro, the same target_valid is ignored and the ramp ends at 10.

Source files
------------

// File: rtl/pdm_fade_ctrl.sv
// pdm_fade_ctrl
//   Fades a PDM modulator setpoint toward a requested target, one LSB per
//   step. Each step is spaced by at least step_period clk cycles (0 acts as 1)
//   and is applied only on a modulator period-start strobe. The setpoint
//   therefore never changes in the middle of a modulator period.
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   target            requested final setpoint
//   target_valid      target request strobe
//   ready             request accepted this cycle when target_valid is 1
//   step_period       clk cycles between steps, sampled on every reload
//   abort             stop the ramp and hold the current setpoint
//   pdm_start_strobe  modulator period-start strobe
//   mod_setpoint      setpoint driven to the modulator
//   busy              ramp in progress
//   done              one-cycle pulse on ramp completion
//
// Configuration macro
//   PDM_FADE_CTRL_RETARGET_EN  defined: a new target may be accepted while
//                              busy. Undefined: requests are accepted in IDLE only.

module pdm_fade_ctrl #(
   parameter int MOD_WIDTH      = 8,
   parameter int STEP_WIDTH     = 16,
   parameter int RESET_SETPOINT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MOD_WIDTH-1:0]  target,
   input  logic                  target_valid,
   output logic                  ready,
   input  logic [STEP_WIDTH-1:0] step_period,
   input  logic                  abort,
   input  logic                  pdm_start_strobe,
   output logic [MOD_WIDTH-1:0]  mod_setpoint,
   output logic                  busy,
   output logic                  done
);

   // state | meaning
   // IDLE  | holding setpoint, waiting for a target request
   // COUNT | prescaler counting down to the next step slot
   // APPLY | step slot open, waiting for the modulator period start
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   localparam logic [MOD_WIDTH-1:0] SP_RST = MOD_WIDTH'(RESET_SETPOINT);
   localparam logic [MOD_WIDTH-1:0] SP_MAX = '1;

   state_t                  state_q, state_d;
   logic [STEP_WIDTH-1:0]   presc_q, presc_d;
   logic [MOD_WIDTH-1:0]    tgt_q, tgt_d;
   logic [MOD_WIDTH-1:0]    sp_q, sp_d;
   logic                    done_q, done_d;

   logic                    retarget;
   logic [MOD_WIDTH-1:0]    eff_tgt;
   logic [MOD_WIDTH-1:0]    sp_step;
   logic [STEP_WIDTH-1:0]   reload;

`ifdef PDM_FADE_CTRL_RETARGET_EN
   assign retarget = target_valid && !abort && (state_q != ST_IDLE);
`else
   assign retarget = 1'b0;
`endif

   // A target arriving in the same cycle as a step already steers that step.
   assign eff_tgt = retarget ? target : tgt_q;

   // step_period of 0 behaves as 1, so the shortest reload is 0.
   assign reload = (step_period == '0) ? '0 : step_period - STEP_WIDTH'(1);

   // Saturating one-LSB move toward the effective target.
   always_comb begin
      sp_step = sp_q;
      if ((eff_tgt > sp_q) && (sp_q != SP_MAX)) begin
         sp_step = sp_q + MOD_WIDTH'(1);
      end else if ((eff_tgt < sp_q) && (sp_q != '0)) begin
         sp_step = sp_q - MOD_WIDTH'(1);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         tgt_q   <= SP_RST;
         sp_q    <= SP_RST;
         done_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tgt_q   <= tgt_d;
         sp_q    <= sp_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tgt_d   = tgt_q;
      sp_d    = sp_q;
      done_d  = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (target_valid) begin
                  tgt_d = target;
                  if (target == sp_q) begin
                     done_d = 1'b1;
                  end else begin
                     presc_d = reload;
                     state_d = ST_COUNT;
                  end
               end
            end

            ST_COUNT, ST_APPLY: begin
               tgt_d = eff_tgt;
               if (eff_tgt == sp_q) begin
                  // only reachable through a retarget onto the current value
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (state_q == ST_COUNT) begin
                  if (presc_q == '0) begin
                     state_d = ST_APPLY;
                  end else begin
                     presc_d = presc_q - STEP_WIDTH'(1);
                  end
               end else if (pdm_start_strobe) begin
                  sp_d = sp_step;
                  if (sp_step == eff_tgt) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     presc_d = reload;
                     state_d = ST_COUNT;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      busy = (state_q != ST_IDLE);
`ifdef PDM_FADE_CTRL_RETARGET_EN
      ready = !abort && !rst;
`else
      ready = (state_q == ST_IDLE) && !abort && !rst;
`endif
   end

   assign mod_setpoint = sp_q;
   assign done         = done_q;

endmodule
